// File: rtl/if_ctrl.sv
// -----------------------------------------------------------------------------
// if_ctrl -- instruction-fetch controller for the MIPS32 core.
//
// Owns the fetch PC, runs the req/ack handshake with instruction memory and
// presents one fetched instruction (with its PC) at a time to IF/ID.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall_i          IF/ID cannot accept; hold the presented instruction
//   branchEnable_i   single-cycle redirect pulse
//   branchAddr_i     redirect target (bits [1:0] forced to 0)
//   imem_req_o       instruction memory request (registered-state decode)
//   imem_addr_o      request address (= fetch PC)
//   imem_ack_i       memory done; imem_data_i valid this cycle
//   imem_data_i      instruction word
//   inst_o, pc_o     presented instruction and its address
//   inst_valid_o     inst_o/pc_o valid
// -----------------------------------------------------------------------------
module if_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branchEnable_i,
  input  logic [31:0] branchAddr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Redirect targets are always word aligned; the low bits are dropped.
  logic [31:0] br_target;
  logic        unused_addr_bits;
  assign br_target        = {branchAddr_i[31:2], 2'b00};
  assign unused_addr_bits = ^branchAddr_i[1:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'h0;
      inst_q      <= 32'h0;
      pc_q        <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the case
    // leaves one unassigned -- that is what keeps this block latch-free.
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (branchEnable_i) fetch_pc_d = br_target;
      end

      FETCH: begin
        if (imem_ack_i) begin
          if (pend_q || branchEnable_i) begin
            // The returning word belongs to a squashed path: drop it and
            // re-issue at the redirect. A same-cycle branch beats pend_addr.
            fetch_pc_d = branchEnable_i ? br_target : pend_addr_q;
            pend_d     = 1'b0;
          end else begin
            inst_d     = imem_data_i;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = VALID;
          end
        end else if (branchEnable_i) begin
          // A request is never withdrawn mid-flight; remember the newest
          // target and apply it when the outstanding ack arrives.
          pend_d      = 1'b1;
          pend_addr_d = br_target;
        end
      end

      VALID: begin
        if (branchEnable_i) begin
          valid_d    = 1'b0;
          fetch_pc_d = br_target;
          state_d    = FETCH;
        end else if (!stall_i) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registers only, no input-to-output paths.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req_o   = (state_q == FETCH);
    imem_addr_o  = fetch_pc_q;
    inst_o       = inst_q;
    pc_o         = pc_q;
    inst_valid_o = valid_q;
  end

endmodule

// File: tb/tb_if_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_ctrl -- directed testbench for if_ctrl with a latency-programmable
// instruction memory model.
// -----------------------------------------------------------------------------
module tb_if_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branchEnable_i = 1'b0;
  logic [31:0] branchAddr_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  int cnt    = 0;

  if_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .branchEnable_i(branchEnable_i),
    .branchAddr_i  (branchAddr_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed, address-dependent pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: acks `lat` cycles after a request starts (0 = same cycle).
  // Driven on the falling edge; req/addr are registered so they are stable.
  always @(negedge clk) begin
    if (rst || !imem_req_o) begin
      imem_ack_i = 1'b0;
      cnt        = 0;
    end else if (cnt >= lat) begin
      imem_ack_i  = 1'b1;
      imem_data_i = mem_word(imem_addr_o);
      cnt         = 0;
    end else begin
      imem_ack_i = 1'b0;
      cnt        = cnt + 1;
    end
  end

  // Advance one clock and sample away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string name, input logic req, input logic [31:0] addr);
    checks++;
    if (imem_req_o !== req) begin
      errors++;
      $display("FAIL %s req: got %0b want %0b", name, imem_req_o, req);
    end
    if (req) begin
      checks++;
      if (imem_addr_o !== addr) begin
        errors++;
        $display("FAIL %s addr: got %h want %h", name, imem_addr_o, addr);
      end
    end
  endtask

  task automatic chk_valid(input string name, input logic v);
    checks++;
    if (inst_valid_o !== v) begin
      errors++;
      $display("FAIL %s valid: got %0b want %0b", name, inst_valid_o, v);
    end
  endtask

  task automatic chk_inst(input string name, input logic [31:0] pc);
    checks++;
    if (pc_o !== pc) begin
      errors++;
      $display("FAIL %s pc: got %h want %h", name, pc_o, pc);
    end
    checks++;
    if (inst_o !== mem_word(pc)) begin
      errors++;
      $display("FAIL %s inst: got %h want %h", name, inst_o, mem_word(pc));
    end
  endtask

  // Step until inst_valid_o rises (bounded), then check the presented word.
  task automatic wait_valid(input string name, input logic [31:0] pc);
    int n = 0;
    step();
    while (inst_valid_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (inst_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: valid got %0b want 1", name, inst_valid_o);
    end else begin
      chk_inst(name, pc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    lat = 0;
    do_reset();
    chk_req("rst", 1'b0, 32'h0);
    checks++;
    if (imem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL rst addr: got %h want %h", imem_addr_o, 32'h0);
    end
    chk_valid("rst", 1'b0);
    checks++;
    if (inst_o !== 32'h0 || pc_o !== 32'h0) begin
      errors++;
      $display("FAIL rst inst/pc: got %h/%h want 0/0", inst_o, pc_o);
    end
    step();
    chk_req("first_req", 1'b1, 32'h0);
    chk_valid("first_req", 1'b0);
    step();
    chk_valid("l0_pc0", 1'b1);
    chk_inst("l0_pc0", 32'h0);
    chk_req("l0_pc0", 1'b0, 32'h0);
    step();
    chk_valid("l0_gap", 1'b0);
    chk_req("l0_gap", 1'b1, 32'h4);
    step();
    chk_valid("l0_pc4", 1'b1);
    chk_inst("l0_pc4", 32'h4);
    step();
    step();
    chk_valid("l0_pc8", 1'b1);
    chk_inst("l0_pc8", 32'h8);
  endtask

  // Entered while VALID with pc_o = 0x8.
  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_valid("stall", 1'b1);
      chk_inst("stall", 32'h8);
      chk_req("stall", 1'b0, 32'h0);
    end
    stall_i = 1'b0;
    step();
    chk_req("stall_release", 1'b1, 32'hC);
    chk_valid("stall_release", 1'b0);
    wait_valid("stall_next", 32'hC);
  endtask

  task automatic test_branch_wait();
    lat = 3;
    do_reset();
    wait_valid("l3_pc0", 32'h0);
    step();                                   // fetch of 0x4, cycle 0
    step();                                   // cycle 1
    chk_req("bw_c1", 1'b1, 32'h4);
    branchEnable_i = 1'b1;
    branchAddr_i   = 32'h100;
    step();
    branchEnable_i = 1'b0;
    chk_req("bw_c2", 1'b1, 32'h4);
    chk_valid("bw_c2", 1'b0);
    step();
    chk_req("bw_c3", 1'b1, 32'h4);
    step();                                   // ack sampled, data discarded
    chk_valid("bw_discard", 1'b0);
    chk_req("bw_redirect", 1'b1, 32'h100);
    wait_valid("bw_target", 32'h100);
  endtask

  // Entered while VALID with pc_o = 0x100.
  task automatic test_branch_valid_stall();
    stall_i        = 1'b1;
    branchEnable_i = 1'b1;
    branchAddr_i   = 32'h203;
    step();
    branchEnable_i = 1'b0;
    stall_i        = 1'b0;
    chk_valid("bvs_squash", 1'b0);
    chk_req("bvs_squash", 1'b1, 32'h200);
    wait_valid("bvs_target", 32'h200);
  endtask

  // Entered while VALID with pc_o = 0x200.
  task automatic test_double_branch();
    lat = 4;
    step();                                   // fetch 0x204, cycle 0
    branchEnable_i = 1'b1;
    branchAddr_i   = 32'h40;
    step();                                   // cycle 1
    branchAddr_i   = 32'h80;
    step();                                   // cycle 2
    branchEnable_i = 1'b0;
    step();                                   // cycle 3
    step();                                   // cycle 4 (ack)
    chk_req("db_hold", 1'b1, 32'h204);
    step();
    chk_req("db_newest", 1'b1, 32'h80);
    chk_valid("db_newest", 1'b0);
    wait_valid("db_target", 32'h80);
    branchEnable_i = 1'b1;
    branchAddr_i   = 32'hFFFF_FFFC;
    step();
    branchEnable_i = 1'b0;
    chk_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
    wait_valid("wrap_inst", 32'hFFFF_FFFC);
    step();
    chk_req("wrap_next", 1'b1, 32'h0);
  endtask

  // Entered in FETCH of 0x0, cycle 0, lat = 4.
  task automatic test_branch_at_ack();
    branchEnable_i = 1'b1;
    branchAddr_i   = 32'h300;
    step();                                   // cycle 1
    branchEnable_i = 1'b0;
    step();                                   // cycle 2
    step();                                   // cycle 3
    step();                                   // cycle 4 (ack)
    branchEnable_i = 1'b1;
    branchAddr_i   = 32'h400;
    step();
    branchEnable_i = 1'b0;
    chk_req("ack_br_prio", 1'b1, 32'h400);
    chk_valid("ack_br_prio", 1'b0);
    wait_valid("ack_br_target", 32'h400);
  endtask

  // Entered while VALID with pc_o = 0x400.
  task automatic test_reset_mid();
    lat = 3;
    step();                                   // fetch 0x404, cycle 0
    step();                                   // cycle 1
    chk_req("rm_busy", 1'b1, 32'h404);
    rst = 1'b1;
    step();
    chk_req("rm_in_rst", 1'b0, 32'h0);
    chk_valid("rm_in_rst", 1'b0);
    step();
    rst = 1'b0;
    step();
    chk_req("rm_restart", 1'b1, 32'h0);
    wait_valid("rm_first", 32'h0);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch_wait();
    test_branch_valid_stall();
    test_double_branch();
    test_branch_at_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
